// File: rtl/ft_tx_arb_if.sv
// Signal bundle for ft_tx_arb: two byte-stream sources, the FT245 Tx stream,
// and the grant/error status. "slave" is the arbiter side, "master" its environment.
interface ft_tx_arb_if;
  logic [7:0] i_s0_data;
  logic       i_s0_valid;
  logic       i_s0_last;
  logic       o_s0_ready;
  logic [7:0] i_s1_data;
  logic       i_s1_valid;
  logic       i_s1_last;
  logic       o_s1_ready;
  logic [7:0] o_tx_data;
  logic       o_tx_valid;
  logic       i_tx_ready;
  logic [1:0] o_grant;
  logic       o_err_len;

  modport slave (
    input  i_s0_data, i_s0_valid, i_s0_last,
    input  i_s1_data, i_s1_valid, i_s1_last,
    input  i_tx_ready,
    output o_s0_ready, o_s1_ready,
    output o_tx_data, o_tx_valid,
    output o_grant, o_err_len
  );

  modport master (
    output i_s0_data, i_s0_valid, i_s0_last,
    output i_s1_data, i_s1_valid, i_s1_last,
    output i_tx_ready,
    input  o_s0_ready, o_s1_ready,
    input  o_tx_data, o_tx_valid,
    input  o_grant, o_err_len
  );
endinterface

// File: rtl/ft_tx_arb.sv
// Round-robin, packet-atomic arbiter sharing the FT245 Tx byte stream between two sources.
// Optional macro FT_TX_ARB_TAG_EN prefixes each granted packet with a source tag byte (A0/A1).
module ft_tx_arb #(
  parameter int MAX_PKT_LEN = 256,
  parameter int CNT_WIDTH   = 16
) (
  input logic        i_clk,
  input logic        i_rst,
  ft_tx_arb_if.slave bus
);

  typedef enum logic [1:0] {ST_IDLE, ST_TAG, ST_PASS} state_t;

  // Counter value of the byte whose transfer makes the packet MAX_PKT_LEN long
  localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(MAX_PKT_LEN - 1);

  state_t               state_reg, state_next;
  logic                 owner_reg, owner_next;
  logic                 ptr_reg, ptr_next;
  logic [CNT_WIDTH-1:0] cnt_reg, cnt_next;
  logic                 err_len_reg, err_len_next;

  logic [7:0] src_data [2];
  logic [1:0] src_valid;
  logic [1:0] src_last;
  logic [1:0] src_ready;
  logic [1:0] grant;
  logic [7:0] sel_data;
  logic       sel_valid;
  logic       sel_last;
  logic [7:0] tx_data;
  logic       tx_valid;

  assign src_data[0]  = bus.i_s0_data;
  assign src_data[1]  = bus.i_s1_data;
  assign src_valid    = {bus.i_s1_valid, bus.i_s0_valid};
  assign src_last     = {bus.i_s1_last, bus.i_s0_last};
  assign bus.o_s0_ready = src_ready[0];
  assign bus.o_s1_ready = src_ready[1];

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_src
      assign grant[gi]     = (state_reg != ST_IDLE) && (owner_reg == 1'(gi));
      assign src_ready[gi] = (state_reg == ST_PASS) && (owner_reg == 1'(gi)) && bus.i_tx_ready;
    end
  endgenerate

  // Only the granted source is ever looked at
  always_comb begin
    sel_data  = src_data[owner_reg];
    sel_valid = src_valid[owner_reg];
    sel_last  = src_last[owner_reg];
  end

  always_comb begin
    state_next   = state_reg;
    owner_next   = owner_reg;
    ptr_next     = ptr_reg;
    cnt_next     = cnt_reg;
    err_len_next = 1'b0;
    tx_data      = 8'h00;
    tx_valid     = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (|src_valid) begin
          owner_next = (&src_valid) ? ptr_reg : src_valid[1];
`ifdef FT_TX_ARB_TAG_EN
          state_next = ST_TAG;
`else
          state_next = ST_PASS;
`endif
        end
      end
`ifdef FT_TX_ARB_TAG_EN
      ST_TAG: begin
        tx_valid = 1'b1;
        tx_data  = {7'b1010_000, owner_reg};
        if (bus.i_tx_ready) begin
          state_next = ST_PASS;
        end
      end
`endif
      ST_PASS: begin
        tx_data  = sel_data;
        tx_valid = sel_valid;
        if (sel_valid && bus.i_tx_ready) begin
          if (sel_last || (cnt_reg == LAST_CNT)) begin
            // A length cutoff leaves the rest of the packet to be re-arbitrated
            state_next   = ST_IDLE;
            ptr_next     = ~owner_reg;
            cnt_next     = '0;
            err_len_next = ~sel_last;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg   <= ST_IDLE;
      owner_reg   <= 1'b0;
      ptr_reg     <= 1'b0;
      cnt_reg     <= '0;
      err_len_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      owner_reg   <= owner_next;
      ptr_reg     <= ptr_next;
      cnt_reg     <= cnt_next;
      err_len_reg <= err_len_next;
    end
  end

  assign bus.o_tx_data  = tx_data;
  assign bus.o_tx_valid = tx_valid;
  assign bus.o_grant    = grant;
  assign bus.o_err_len  = err_len_reg;

endmodule

// File: doc/ft_tx_arb.md
Name: ft_tx_arb

Overview:
- Packet-level arbiter that shares the single FT245 Tx byte stream between two byte-stream requesters.
- Source 0 carries command responses from the Wishbone command engine; source 1 carries bulk streaming data.
- Grants are round-robin and packet-atomic: once a packet starts, it owns the Tx stream until its last byte or a length-limit cutoff.
- Sits between the command/stream producers and the ft245sync Tx interface, in the ft245sync clock domain.

Parameters:
- MAX_PKT_LEN, 256: maximum bytes per granted packet before forced release. Range 2..65535.
- CNT_WIDTH, 16: width of the byte counter. Must satisfy 2^CNT_WIDTH > MAX_PKT_LEN.

Ports:
- i_clk  in  1  system clock (ft245sync o_clk)
- i_rst  in  1  synchronous reset, active-high
- i_s0_data  in  8  source 0 byte
- i_s0_valid  in  1  source 0 byte valid
- i_s0_last  in  1  source 0 byte is last of packet
- o_s0_ready  out  1  source 0 byte accepted when valid&&ready
- i_s1_data  in  8  source 1 byte
- i_s1_valid  in  1  source 1 byte valid
- i_s1_last  in  1  source 1 last of packet
- o_s1_ready  out  1  source 1 ready
- o_tx_data  out  8  byte to ft245sync Tx
- o_tx_valid  out  1  Tx valid
- i_tx_ready  in  1  Tx ready from ft245sync
- o_grant  out  2  one-hot current owner; 00 when idle
- o_err_len  out  1  one-cycle pulse on forced release at MAX_PKT_LEN

Behaviour:
- Clock and reset: one clock, i_clk. i_rst is synchronous and active-high.
- Reset values:
  - state=IDLE, o_grant=00, o_err_len=0, counter=0.
  - Round-robin pointer points to source 0 (s0 wins the first tie).
  - o_tx_valid=0, o_s0_ready=0, o_s1_ready=0.
- Transfers: a beat transfers only when valid&&ready on the same edge. Outputs never depend on the un-granted source.
- State IDLE:
  - Tx outputs idle.
  - Requests are i_s0_valid and i_s1_valid.
  - If only one requests, grant it. If both request, grant the one the pointer selects.
  - Move to PASS (or TAG when the feature is enabled) on the next cycle. Grant latency is 1 cycle; the first byte can transfer in the cycle after the request is seen.
- State PASS (grant g), combinational pass-through:
  - o_tx_data = i_sg_data, o_tx_valid = i_sg_valid, o_sg_ready = i_tx_ready.
  - The other source's ready = 0.
  - Each transferred byte increments the counter.
- Release from PASS: release happens on the transfer of a byte that either has i_sg_last=1 or makes counter+1 == MAX_PKT_LEN.
  - On release: state goes to IDLE, o_grant=00, the pointer moves to the other source, and the counter clears.
  - If release is due to length only (last=0), pulse o_err_len=1 for one cycle. The remainder of that packet is arbitrated as a new packet.
  - last=1 on the exact MAX_PKT_LEN-th byte is a normal release: no error.
- No bubble-free back-to-back: at least one IDLE cycle between packets.
- Simultaneous events:
  - A request arriving while the other source is in PASS waits; no preemption.
  - valid low mid-packet holds the grant indefinitely, with o_tx_valid=0.
- Single-byte packet (last on first byte): 1 transfer, then release.
- Reset mid-packet: immediate return to reset values. The partial packet is abandoned; the sources keep their byte and re-request.
- Width rules: the counter saturates logically via release and never wraps.

Optional Feature:
- Macro: FT_TX_ARB_TAG_EN.
- When defined:
  - A state TAG is inserted between IDLE and PASS.
  - TAG drives o_tx_valid=1, o_tx_data = 8'hA0 | g (8'hA0 for s0, 8'hA1 for s1), with both source readies 0.
  - Advance to PASS on i_tx_ready. The tag is not counted toward MAX_PKT_LEN.
  - After a length-forced release, the continuation gets a new tag.
- When undefined: no TAG state, no tag byte; IDLE goes directly to PASS.

Test Plan:
- Reset, then s0 sends 3-byte packet 11,22,33(last) with i_tx_ready=1:
  - Tx sees 11,22,33; o_grant=01 during transfer, 00 after; o_err_len never set.
- s0 and s1 both valid from reset, each with 2-byte packets (s0: 01,02; s1: 81,82), both re-requesting:
  - Tx order is 01,02,81,82,01,02; grants alternate, starting with s0.
- MAX_PKT_LEN=4, s1 sends 6 bytes 00..05 with last on 05:
  - o_err_len pulses once after byte 03.
  - 04,05 go out as a second grant.
  - If s0 is waiting at the cutoff, s0's packet goes out between 03 and 04.
- s0 in PASS, i_tx_ready toggled 1,0,0,1 and s0 valid dropped for 2 cycles mid-packet:
  - No byte is lost or duplicated; the grant stays 01; o_s1_ready stays 0 throughout.
- Assert i_rst for 1 cycle after the 2nd byte of a 5-byte s1 packet:
  - Next cycle all outputs are at reset values.
  - s1 resubmits: the packet restarts, with the counter at 0.
- With FT_TX_ARB_TAG_EN, s1 single-byte packet 5A(last), i_tx_ready=1:
  - Tx sees A1,5A; o_s1_ready=0 during the A1 cycle.
